// File: rtl/bus_demux.sv
// Registered 1:2 bus demultiplexer: one input stream is steered by in_sel into one of
// two single-entry output channels, each with valid/ready handshake and a delivered-word counter.
module bus_demux #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_1,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [WIDTH-1:0] out_2,
  output logic             out_2_valid,
  input  logic             out_2_ready,
  output logic [CNT_W-1:0] cnt_1,
  output logic [CNT_W-1:0] cnt_2
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           st_1, st_2;
  logic [WIDTH-1:0] data_1, data_2;
  logic [CNT_W-1:0] count_1, count_2;
  logic             sel_ready;
  logic             load_1, load_2;
  logic             drain_1, drain_2;

  // Only the addressed channel gates acceptance; the other channel never stalls the input.
  assign sel_ready = in_sel ? ((st_2 == EMPTY) || out_2_ready)
                            : ((st_1 == EMPTY) || out_1_ready);
  assign in_ready  = ~rst & sel_ready;

  assign load_1  = in_valid & in_ready & ~in_sel;
  assign load_2  = in_valid & in_ready &  in_sel;
  assign drain_1 = (st_1 == FULL) & out_1_ready;
  assign drain_2 = (st_2 == FULL) & out_2_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_1    <= EMPTY;
      st_2    <= EMPTY;
      data_1  <= '0;
      data_2  <= '0;
      count_1 <= '0;
      count_2 <= '0;
    end else begin
      // A load wins over a drain, so a same-cycle drain+load keeps the channel FULL.
      if (load_1) begin
        data_1 <= in_data;
        st_1   <= FULL;
      end else if (drain_1) begin
        st_1   <= EMPTY;
      end
      if (load_2) begin
        data_2 <= in_data;
        st_2   <= FULL;
      end else if (drain_2) begin
        st_2   <= EMPTY;
      end
      if (drain_1) count_1 <= count_1 + CNT_W'(1);
      if (drain_2) count_2 <= count_2 + CNT_W'(1);
    end
  end

  assign out_1       = data_1;
  assign out_2       = data_2;
  assign out_1_valid = (st_1 == FULL);
  assign out_2_valid = (st_2 == FULL);
  assign cnt_1       = count_1;
  assign cnt_2       = count_2;

endmodule

// File: tb/tb_bus_demux.sv
// Bench for bus_demux: directed vector table, hand sequences for reset and counter wrap,
// and random traffic checked against a queue-based reference model.
module tb_bus_demux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_1, out_2;
  logic       out_1_valid, out_2_valid;
  logic       out_1_ready = 1'b0;
  logic       out_2_ready = 1'b0;
  logic [7:0] cnt_1, cnt_2;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel is a queue of held words plus a delivered count.
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [3:0] last1, last2;
  int         n1, n2;

  bus_demux #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_1(out_1), .out_1_valid(out_1_valid), .out_1_ready(out_1_ready),
    .out_2(out_2), .out_2_valid(out_2_valid), .out_2_ready(out_2_ready),
    .cnt_1(cnt_1), .cnt_2(cnt_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    n1 = 0;
    n2 = 0;
  endtask

  function automatic bit model_ready();
    if (in_sel) return (q2.size() == 0) || (out_2_ready == 1'b1);
    else        return (q1.size() == 0) || (out_1_ready == 1'b1);
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    bit acc;
    acc = in_valid && model_ready();
    if (q1.size() != 0 && out_1_ready) begin void'(q1.pop_front()); n1++; end
    if (q2.size() != 0 && out_2_ready) begin void'(q2.pop_front()); n2++; end
    if (acc && !in_sel) begin q1.push_back(in_data); last1 = in_data; end
    if (acc &&  in_sel) begin q2.push_back(in_data); last2 = in_data; end
  endtask

  task automatic model_check();
    chk("v1", int'(out_1_valid), int'(q1.size() != 0));
    chk("v2", int'(out_2_valid), int'(q2.size() != 0));
    if (q1.size() != 0) chk("d1", int'(out_1), int'(q1[0]));
    else                chk("d1_hold", int'(out_1), int'(last1));
    if (q2.size() != 0) chk("d2", int'(out_2), int'(q2[0]));
    else                chk("d2_hold", int'(out_2), int'(last2));
    chk("c1", int'(cnt_1), n1 % 256);
    chk("c2", int'(cnt_2), n2 % 256);
  endtask

  // Called just after a falling edge: drive, check in_ready, clock, check outputs.
  task automatic cycle(input logic v, input logic s, input logic [3:0] d,
                       input logic r1, input logic r2);
    in_valid = v; in_sel = s; in_data = d; out_1_ready = r1; out_2_ready = r2;
    #1;
    chk("in_ready", int'(in_ready), int'(model_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_v1"}, int'(out_1_valid), 0);
    chk({tag, "_v2"}, int'(out_2_valid), 0);
    chk({tag, "_d1"}, int'(out_1), 0);
    chk({tag, "_d2"}, int'(out_2), 0);
    chk({tag, "_c1"}, int'(cnt_1), 0);
    chk({tag, "_c2"}, int'(cnt_2), 0);
    chk({tag, "_rdy"}, int'(in_ready), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b1; in_sel = 1'b0; out_1_ready = 1'b1; out_2_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_state("rst_now");
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_held");
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic       v, s;
    logic [3:0] d;
    logic       r1, r2;
    logic       rdy;
    logic       v1;
    logic [3:0] d1;
    logic       v2;
    logic [3:0] d2;
    logic [7:0] c1, c2;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //            v  s  d     r1 r2 rdy v1 d1    v2 d2    c1 c2
    tbl[0] = '{1, 0, 4'hA, 1, 1, 1, 1, 4'hA, 0, 4'h0, 0, 0};
    tbl[1] = '{1, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 4'h5, 1, 0};
    tbl[2] = '{0, 0, 4'h0, 1, 1, 1, 0, 4'hA, 0, 4'h5, 1, 1};
    tbl[3] = '{1, 0, 4'h3, 0, 1, 1, 1, 4'h3, 0, 4'h5, 1, 1};
    tbl[4] = '{1, 0, 4'h7, 0, 1, 0, 1, 4'h3, 0, 4'h5, 1, 1};
    tbl[5] = '{1, 0, 4'h7, 1, 1, 1, 1, 4'h7, 0, 4'h5, 2, 1};
    tbl[6] = '{1, 1, 4'hC, 0, 1, 1, 1, 4'h7, 1, 4'hC, 2, 1};
    tbl[7] = '{0, 1, 4'h0, 0, 1, 1, 1, 4'h7, 0, 4'hC, 2, 2};
    tbl[8] = '{1, 0, 4'h1, 0, 0, 0, 1, 4'h7, 0, 4'hC, 2, 2};
    tbl[9] = '{0, 0, 4'h0, 1, 0, 1, 0, 4'h7, 0, 4'hC, 3, 2};

    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].s; in_data = tbl[i].d;
      out_1_ready = tbl[i].r1; out_2_ready = tbl[i].r2;
      #1;
      chk($sformatf("tbl%0d_rdy", i), int'(in_ready), int'(tbl[i].rdy));
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk($sformatf("tbl%0d_v1", i), int'(out_1_valid), int'(tbl[i].v1));
      chk($sformatf("tbl%0d_d1", i), int'(out_1), int'(tbl[i].d1));
      chk($sformatf("tbl%0d_v2", i), int'(out_2_valid), int'(tbl[i].v2));
      chk($sformatf("tbl%0d_d2", i), int'(out_2), int'(tbl[i].d2));
      chk($sformatf("tbl%0d_c1", i), int'(cnt_1), int'(tbl[i].c1));
      chk($sformatf("tbl%0d_c2", i), int'(cnt_2), int'(tbl[i].c2));
    end

    // Build up both channels FULL with counters at 5 and 3, then reset mid-stream.
    cycle(1, 0, 4'h1, 1, 1);
    cycle(1, 1, 4'h2, 1, 1);
    cycle(1, 0, 4'h3, 1, 1);
    cycle(1, 1, 4'h4, 1, 1);
    cycle(1, 0, 4'h6, 0, 0);
    chk("pre_rst_c1", int'(cnt_1), 5);
    chk("pre_rst_c2", int'(cnt_2), 3);
    chk("pre_rst_v1", int'(out_1_valid), 1);
    chk("pre_rst_v2", int'(out_2_valid), 1);
    do_reset();

    // Back-to-back streaming on channel 2.
    for (int i = 0; i < 16; i++) begin
      cycle(1, 1, 4'(i), 1, 1);
      chk("stream_rdy_hi", int'(in_ready), 1);
      chk("stream_d2", int'(out_2), i);
    end
    cycle(0, 1, 4'h0, 1, 1);
    chk("stream_c2", int'(cnt_2), 16);

    // Counter wrap on channel 1 after 257 deliveries.
    do_reset();
    for (int i = 0; i < 256; i++) cycle(1, 0, 4'(i), 1, 0);
    chk("wrap_255", int'(cnt_1), 255);
    cycle(1, 0, 4'h0, 1, 0);
    chk("wrap_0", int'(cnt_1), 0);
    cycle(0, 0, 4'h0, 1, 0);
    chk("wrap_1", int'(cnt_1), 1);
    chk("wrap_c2", int'(cnt_2), 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_demux.md
# bus_demux

Registered 1:2 bus demultiplexer: the steering counterpart to the team's 2:1 bus select. One WIDTH-bit input stream is routed by a per-transfer select bit to one of two output channels. Each channel has a one-entry holding register with valid/ready handshake and a wrapping delivered-transfer counter. The block sits where a shared bus fans out to two independent consumers.

## Interface
- WIDTH, 4, data bus width in bits
- CNT_W, 8, width of each delivered-transfer counter
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  input data word
- in_sel  input  1  destination: 0 selects channel 1, 1 selects channel 2; sampled with in_data
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle
- out_1  output  WIDTH  channel 1 data
- out_1_valid  output  1  channel 1 holds a word
- out_1_ready  input  1  channel 1 consumer accepts
- out_2  output  WIDTH  channel 2 data
- out_2_valid  output  1  channel 2 holds a word
- out_2_ready  input  1  channel 2 consumer accepts
- cnt_1  output  CNT_W  words delivered on channel 1, mod 2^CNT_W
- cnt_2  output  CNT_W  words delivered on channel 2, mod 2^CNT_W

## Operation
- Each channel has an independent 2-state FSM: EMPTY (valid=0) and FULL (valid=1). out_N_valid is the FSM state.
- Accept: in_valid & in_ready. On accept, the selected channel's register loads in_data and that channel goes or stays FULL.
- in_ready = ~rst & (~out_S_valid | out_S_ready), where S is the channel named by in_sel. This is combinational from in_sel, the selected valid, and the selected ready. It is independent of in_valid.
- Drain: out_N_valid & out_N_ready. Drain takes channel N to EMPTY unless the same cycle also loads channel N.
- Drain and load on the same channel in the same cycle: the channel stays FULL, out_N takes the new word, and cnt_N increments. This gives full throughput of one word per cycle per channel.
- The unselected channel is unaffected by the input. It may drain in the same cycle that the other channel loads.
- While out_N_valid=1 and out_N_ready=0, out_N is held stable.
- Words are never dropped or duplicated. Per-channel order equals input order for that select value.
- Counters: cnt_N increments by 1 on each channel-N drain and wraps from 2^CNT_W-1 to 0 without flagging.
- in_data and in_sel are ignored when in_valid=0.
- out_N data while EMPTY holds its last loaded value. Consumers must not rely on it.

## Timing
- Reset values, applied immediately on rst assertion:
  - out_1_valid=0, out_2_valid=0
  - out_1=0, out_2=0
  - cnt_1=0, cnt_2=0
  - in_ready=0 while rst=1
- Reset mid-operation: held words are discarded and counters clear. No transfer is accepted or delivered while rst=1.
- First accept is possible on the first rising edge with rst=0.
- Latency: a word accepted at edge k appears with out_N_valid=1 after edge k, so it is consumable at edge k+1.
- Throughput: 1 word/cycle into either channel when its consumer holds ready=1. The two channels together still take at most 1 input word/cycle.
- Backpressure: with channel N FULL and out_N_ready=0, in_ready=0 for in_sel=N. in_ready remains 1 for the other channel if that channel is EMPTY or draining.

## Test plan
- Reset: assert rst mid-stream with both channels FULL and counters at 5 and 3. Required: all valids, data and counters read 0 immediately, and in_ready=0 until rst deasserts.
- Steering: send 4'hA with sel=0, then 4'h5 with sel=1, with both readies high. Required: out_1=A valid for one cycle after the first edge, out_2=5 valid one cycle later, and cnt_1=1, cnt_2=1.
- Backpressure: hold out_1_ready=0 and send 4'h3 with sel=0, then 4'h7 with sel=0. Required: out_1 holds 3 and in_ready=0 for sel=0. Then raise ready: 3 drains and 7 loads on the same edge, out_1 becomes 7, and cnt_1 increments once per drain.
- Cross-channel independence: channel 1 FULL and stalled, then send 4'hC with sel=1. Required: in_ready=1, 4'hC is delivered on channel 2, and channel 1 is unchanged.
- Streaming: send 16 back-to-back words 0..F with sel=1 and out_2_ready=1. Required: in_ready stays 1, out_2 presents 0..F on consecutive cycles, and cnt_2=16.
- Counter wrap: with CNT_W=8, deliver 257 words on channel 1. Required: cnt_1 reads 255 then 0 then 1, and cnt_2 stays 0.
